// File: rtl/keypad_if.sv
// -----------------------------------------------------------------------------
// keypad_if
//   Bundles the keypad matrix pins and the decoded-key outputs of the keypad
//   scanner into one connection.
//
//   Signals:
//     row_in    [3:0]  matrix rows, active-low; asynchronous to the scanner clock
//     col_out   [3:0]  column drive, active-low one-hot
//     key_code  [3:0]  code of the accepted key (row*4 + col)
//     key_valid        one-cycle pulse per accepted key (and per auto-repeat)
//     key_held         high from acceptance until debounced release
//
//   Modports:
//     master  the scanner: reads the rows, drives the columns and key outputs
//     slave   the board/consumer side: drives the rows, reads everything else
// -----------------------------------------------------------------------------
interface keypad_if;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  row_in,
      output col_out,
      output key_code,
      output key_valid,
      output key_held
   );

   modport slave (
      output row_in,
      input  col_out,
      input  key_code,
      input  key_valid,
      input  key_held
   );
endinterface

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 passive key matrix: one column is driven low at a time, the
//   rows are sampled at the end of each column slot, and once per full scan
//   the 16-key snapshot is reduced to a single candidate key (or none). The
//   candidate is debounced over whole scans and reported as a 4-bit code with
//   a one-cycle valid pulse and a held level.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-low reset
//     kp     keypad_if.master
//              row_in   (in)  rows, active-low, asynchronous
//              col_out  (out) active-low one-hot column drive
//              key_code (out) accepted key = row*4 + col, holds last value
//              key_valid(out) one-cycle pulse on acceptance
//              key_held (out) high until debounced release
//
//   Parameters:
//     SCAN_DIV        cycles each column is driven (>= 4)
//     DEBOUNCE_SCANS  identical full scans needed to accept a press/release (1..15)
//     REPEAT_SCANS    full scans between auto-repeat pulses
//
//   Build option:
//     KEYPAD_REPEAT_EN  when defined, a held key re-pulses key_valid every
//                       REPEAT_SCANS scans; when undefined there is no repeat
//                       logic and each accepted press pulses exactly once.
// -----------------------------------------------------------------------------
module keypad_scanner #(
   parameter int SCAN_DIV       = 4,
   parameter int DEBOUNCE_SCANS = 3,
   parameter int REPEAT_SCANS   = 8
) (
   input  logic     clk,
   input  logic     reset,
   keypad_if.master kp
);

   localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_DIV - 1);
   localparam logic [3:0]    DB_TARGET  = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } state_t;

   // Out-of-range parameter combinations elaborate this (empty) marker block,
   // which makes a bad configuration easy to spot in the elaborated hierarchy.
   if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 ||
       REPEAT_SCANS < 1) begin : g_illegal_parameters
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [3:0]    row_meta_reg;
   logic [3:0]    row_sync_reg;

   logic [TW-1:0] timer_reg,     timer_next;
   logic [1:0]    col_idx_reg,   col_idx_next;
   logic [3:0]    col_reg,       col_next;

   state_t        state_reg,     state_next;
   logic          prev_none_reg, prev_none_next;
   logic [3:0]    prev_code_reg, prev_code_next;
   logic [3:0]    stable_reg,    stable_next;

   logic [3:0]    code_reg,      code_next;
   logic          valid_reg,     valid_next;
   logic          held_reg,      held_next;

   // ------------------------------------------------------------------------
   // Scan timing
   // ------------------------------------------------------------------------
   logic terminal;
   logic end_of_scan;

   assign terminal    = (timer_reg == TIMER_LAST);
   assign end_of_scan = terminal && (col_idx_reg == 2'd3);

   // ------------------------------------------------------------------------
   // Per-column snapshot. Each column slot keeps its own 4-bit capture of the
   // synchronized rows (inverted so 1 = pressed). scan_word is the snapshot
   // as it will look after this edge, so at end-of-scan it already contains
   // column 3's rows being captured on the same edge.
   // ------------------------------------------------------------------------
   logic [15:0] scan_word;

   for (genvar gi = 0; gi < 4; gi++) begin : g_col
      logic       capture;
      logic [3:0] col_snap_reg;

      assign capture = terminal && (col_idx_reg == 2'(gi));
      assign scan_word[gi*4 +: 4] = capture ? ~row_sync_reg : col_snap_reg;

      always_ff @(posedge clk) begin
         if (!reset) begin
            col_snap_reg <= 4'b0000;
         end else if (capture) begin
            col_snap_reg <= ~row_sync_reg;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Candidate: exactly one pressed bit gives that key; zero or several
   // (multi-press, ghosting) give NONE. Snapshot bit index is col*4+row while
   // the key code is row*4+col, so the two 2-bit halves swap.
   // ------------------------------------------------------------------------
   logic [4:0] ones_cnt;
   logic [3:0] hit_idx;
   logic       cand_none;
   logic [3:0] cand_code;

   always_comb begin
      ones_cnt = 5'd0;
      hit_idx  = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (scan_word[i]) begin
            ones_cnt = ones_cnt + 5'd1;
            hit_idx  = 4'(i);
         end
      end
   end

   assign cand_none = (ones_cnt != 5'd1);
   assign cand_code = {hit_idx[1:0], hit_idx[3:2]};

   // ------------------------------------------------------------------------
   // Stability of the candidate across scans, saturating at the debounce
   // target. A NONE candidate matches a previous NONE regardless of code.
   // ------------------------------------------------------------------------
   logic       cand_same;
   logic [3:0] stable_scan;
   logic       stable_done;
   logic       cand_is_latched;

   assign cand_same   = (cand_none == prev_none_reg) &&
                        (cand_none || (cand_code == prev_code_reg));
   assign stable_scan = !cand_same                ? 4'd1 :
                        (stable_reg < DB_TARGET)  ? stable_reg + 4'd1 :
                                                    stable_reg;
   assign stable_done     = (stable_scan == DB_TARGET);
   assign cand_is_latched = !cand_none && (cand_code == code_reg);

`ifdef KEYPAD_REPEAT_EN
   localparam int RW = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_SCANS - 1);
   logic [RW-1:0] rpt_reg, rpt_next;
`endif

   // ------------------------------------------------------------------------
   // Next-state logic: column timer, debounce bookkeeping and key FSM.
   // ------------------------------------------------------------------------
   always_comb begin
      timer_next     = timer_reg;
      col_idx_next   = col_idx_reg;
      col_next       = col_reg;
      state_next     = state_reg;
      prev_none_next = prev_none_reg;
      prev_code_next = prev_code_reg;
      stable_next    = stable_reg;
      code_next      = code_reg;
      valid_next     = 1'b0;
      held_next      = held_reg;
`ifdef KEYPAD_REPEAT_EN
      rpt_next       = rpt_reg;
`endif

      if (terminal) begin
         timer_next   = '0;
         col_idx_next = col_idx_reg + 2'd1;
         // Rotate the single low bit upward: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
         col_next     = {col_reg[2:0], col_reg[3]};
      end else begin
         timer_next   = timer_reg + TW'(1);
      end

      if (end_of_scan) begin
         prev_none_next = cand_none;
         prev_code_next = cand_code;
         stable_next    = stable_scan;

         unique case (state_reg)
            IDLE: begin
               if (!cand_none) begin
                  state_next = PRESS_DB;
               end
            end

            PRESS_DB: begin
               if (cand_none) begin
                  state_next = IDLE;
               end else if (stable_done) begin
                  state_next = HELD;
                  code_next  = cand_code;
                  valid_next = 1'b1;
                  held_next  = 1'b1;
               end
            end

            HELD: begin
               if (!cand_is_latched) begin
                  state_next = REL_DB;
               end
            end

            REL_DB: begin
               if (cand_is_latched) begin
                  // Bounce back to the same key: resume holding, no new pulse.
                  state_next = HELD;
               end else if (stable_done) begin
                  if (cand_none) begin
                     state_next = IDLE;
                     held_next  = 1'b0;
                  end else begin
                     // Rolled over to a different key without a clean release.
                     state_next = HELD;
                     code_next  = cand_code;
                     valid_next = 1'b1;
                  end
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase

`ifdef KEYPAD_REPEAT_EN
         // Counts only scans spent continuously in HELD; entering or leaving
         // HELD restarts the count.
         if (state_reg == HELD && state_next == HELD) begin
            if (rpt_reg == RPT_LAST) begin
               rpt_next   = '0;
               valid_next = 1'b1;
            end else begin
               rpt_next   = rpt_reg + RW'(1);
            end
         end else begin
            rpt_next = '0;
         end
`endif
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         row_meta_reg  <= 4'b1111;
         row_sync_reg  <= 4'b1111;
         timer_reg     <= '0;
         col_idx_reg   <= 2'd0;
         col_reg       <= 4'b1110;
         state_reg     <= IDLE;
         prev_none_reg <= 1'b1;
         prev_code_reg <= 4'd0;
         stable_reg    <= 4'd0;
         code_reg      <= 4'd0;
         valid_reg     <= 1'b0;
         held_reg      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rpt_reg       <= '0;
`endif
      end else begin
         row_meta_reg  <= kp.row_in;
         row_sync_reg  <= row_meta_reg;
         timer_reg     <= timer_next;
         col_idx_reg   <= col_idx_next;
         col_reg       <= col_next;
         state_reg     <= state_next;
         prev_none_reg <= prev_none_next;
         prev_code_reg <= prev_code_next;
         stable_reg    <= stable_next;
         code_reg      <= code_next;
         valid_reg     <= valid_next;
         held_reg      <= held_next;
`ifdef KEYPAD_REPEAT_EN
         rpt_reg       <= rpt_next;
`endif
      end
   end

   assign kp.col_out   = col_reg;
   assign kp.key_code  = code_reg;
   assign kp.key_valid = valid_reg;
   assign kp.key_held  = held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//   Drives a simulated 4x4 key matrix (a set of pressed keys indexed by key
//   code) into keypad_scanner. The rows respond combinationally to the column
//   being driven. A reference model works on whole scans: it reduces the
//   pressed set to a candidate, tracks how many scans in a row the candidate
//   has been identical, and decides from that which key presses are reported.
//   Expected pulses go into a queue; a monitor pops and compares on every
//   key_valid it sees.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

   localparam int DEB = 3;
   localparam int RPT = 8;
   localparam int SCAN_CYC = 16;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   keypad_if kif ();

   keypad_scanner #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (DEB),
      .REPEAT_SCANS   (RPT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (kif)
   );

   // Pressed keys, bit n = key code n (row = n/4, col = n%4).
   logic [15:0] press_mask = 16'h0000;

   always_comb begin
      kif.row_in = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (press_mask[r*4 + c] && !kif.col_out[c]) begin
               kif.row_in[r] = 1'b0;
            end
         end
      end
   end

   int tests = 0;
   int fails = 0;
   logic [3:0] exp_q [$];

   // ---------------- reference model (one step per full scan) -------------
   bit mdl_prev_none;
   int mdl_prev_code;
   int mdl_run;
   bit mdl_holding;
   int mdl_code;
   bit mdl_in_held;
   int mdl_rpt;

   task automatic model_reset();
      mdl_prev_none = 1'b1;
      mdl_prev_code = 0;
      mdl_run       = 0;
      mdl_holding   = 1'b0;
      mdl_code      = 0;
      mdl_in_held   = 1'b0;
      mdl_rpt       = 0;
      exp_q.delete();
   endtask

   task automatic model_scan(input logic [15:0] m);
      bit cnone;
      int code;
      cnone = ($countones(m) != 1);
      code  = 0;
      for (int k = 0; k < 16; k++) if (m[k]) code = k;

      if (cnone == mdl_prev_none && (cnone || code == mdl_prev_code)) mdl_run++;
      else mdl_run = 1;
      mdl_prev_none = cnone;
      mdl_prev_code = code;

      if (!mdl_holding) begin
         if (!cnone && mdl_run == DEB) begin
            mdl_holding = 1'b1;
            mdl_code    = code;
            mdl_in_held = 1'b1;
            mdl_rpt     = 0;
            exp_q.push_back(4'(code));
         end
      end else if (!cnone && code == mdl_code) begin
         if (mdl_in_held) begin
`ifdef KEYPAD_REPEAT_EN
            mdl_rpt++;
            if (mdl_rpt == RPT) begin
               mdl_rpt = 0;
               exp_q.push_back(4'(code));
            end
`endif
         end else begin
            mdl_in_held = 1'b1;
            mdl_rpt     = 0;
         end
      end else begin
         mdl_in_held = 1'b0;
         mdl_rpt     = 0;
         if (mdl_run == DEB) begin
            if (cnone) begin
               mdl_holding = 1'b0;
            end else begin
               mdl_code    = code;
               mdl_in_held = 1'b1;
               exp_q.push_back(4'(code));
            end
         end
      end
   endtask

   // ---------------- checking helpers -------------------------------------
   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // Monitor: every key_valid must match the oldest expected pulse.
   always @(negedge clk) begin
      if (kif.key_valid) begin
         tests++;
         if (!reset) begin
            fails++;
            $display("FAIL valid_during_reset got=1 exp=0");
         end else if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse got code=%0d exp=no pulse", kif.key_code);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (kif.key_code !== e) begin
               fails++;
               $display("FAIL pulse_code got=%0d exp=%0d", kif.key_code, e);
            end else begin
               $display("[TB] pulse code=%0d", kif.key_code);
            end
         end
      end
   end

   // ---------------- stimulus tasks ---------------------------------------
   // One full scan with a fixed pressed set. Must start one half-cycle
   // before the first clock edge of a scan.
   task automatic do_scan(input logic [15:0] m);
      logic [3:0] exp_col;
      @(negedge clk);
      press_mask = m;
      for (int i = 0; i < SCAN_CYC; i++) begin
         @(posedge clk);
         if (i == SCAN_CYC - 1) model_scan(m);
         #1;
         exp_col = ~(4'b0001 << (((i + 1) / 4) % 4));
         check("col_out", int'(kif.col_out), int'(exp_col));
         if (i == 0) begin
            check("missing_pulse_backlog", exp_q.size(), 0);
            exp_q.delete();
         end
      end
      check("key_held", int'(kif.key_held), int'(mdl_holding));
      check("key_code", int'(kif.key_code), mdl_code);
      $display("[TB] scan mask=%04h held=%0d code=%0d", m, kif.key_held, kif.key_code);
   endtask

   // Holds reset low for 'cycles' edges, checks reset values, and releases
   // so that the next do_scan lines up with the first scan.
   task automatic do_reset(input int cycles);
      @(negedge clk);
      reset = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      check("rst_col_out", int'(kif.col_out), 4'b1110);
      check("rst_key_code", int'(kif.key_code), 0);
      check("rst_key_valid", int'(kif.key_valid), 0);
      check("rst_key_held", int'(kif.key_held), 0);
      $display("[TB] reset after %0d cycles", cycles);
      model_reset();
      reset = 1'b1;
   endtask

   // Run part of a scan (never reaching end-of-scan) and then reset.
   task automatic partial_then_reset(input logic [15:0] m, input int k);
      @(negedge clk);
      press_mask = m;
      repeat (k) @(posedge clk);
      do_reset(1);
   endtask

   // ---------------- main sequence ----------------------------------------
   initial begin
      logic [15:0] m;
      int sel, n;

      model_reset();
      do_reset(3);

      // Idle rows: column walk and no pulses.
      repeat (4) do_scan(16'h0000);

      // Key 9 (row 2, col 1): accept, hold without re-pulse, release.
      repeat (6) do_scan(16'h0200);
      repeat (4) do_scan(16'h0000);

      // Key 5 bouncing on alternate scans, then stable.
      for (int b = 0; b < 6; b++) do_scan((b % 2 == 0) ? 16'h0020 : 16'h0000);
      repeat (4) do_scan(16'h0020);
      repeat (4) do_scan(16'h0000);

      // Keys 0 and 15 together are rejected; releasing 15 accepts 0.
      repeat (4) do_scan(16'h8001);
      repeat (4) do_scan(16'h0001);
      repeat (4) do_scan(16'h0000);

      // Key 3 pending in debounce, reset mid-scan, then fresh debounce.
      repeat (2) do_scan(16'h0008);
      partial_then_reset(16'h0008, 7);
      repeat (4) do_scan(16'h0008);
      // Reset while holding: key_held must drop at the next edge.
      partial_then_reset(16'h0008, 5);
      repeat (4) do_scan(16'h0000);

      // Randomized presses, multi-presses and releases.
      for (int s = 0; s < 60; s++) begin
         sel = $urandom_range(0, 9);
         if (sel < 3)      m = 16'h0000;
         else if (sel < 8) m = 16'h0001 << $urandom_range(0, 15);
         else              m = (16'h0001 << $urandom_range(0, 15)) |
                               (16'h0001 << $urandom_range(0, 15));
         n = $urandom_range(1, 6);
         repeat (n) do_scan(m);
         if (s % 17 == 16) partial_then_reset(m, $urandom_range(0, 14));
      end

      repeat (5) do_scan(16'h0000);
      @(negedge clk);
      check("final_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Reads a 4x4 passive key matrix by driving one column low at a time and sampling the four row lines. Complements the display-select scan counter: the display side writes multiplexed outputs, this block reads a multiplexed input.
Reports one debounced key per press as a 4-bit code with a single-cycle valid pulse and a held level. Sits between the board keypad pins and the digit-entry/control logic.

Parameters:
SCAN_DIV, 4, clock cycles each column is driven before its rows are sampled; legal range >= 4.
DEBOUNCE_SCANS, 3, consecutive identical full scans required to accept a press or a release; legal range 1..15.
REPEAT_SCANS, 8, full scans between auto-repeat pulses; used only with KEYPAD_REPEAT_EN.

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-low reset
row_in  input  4  matrix rows, active-low (external pull-ups); asynchronous to clk
col_out  output  4  column drive, active-low one-hot; exactly one bit low at all times
key_code  output  4  code of accepted key = row*4 + col; holds its last value
key_valid  output  1  one-cycle pulse when a key is accepted
key_held  output  1  high from acceptance until debounced release

Behaviour:
- Reset (reset=0 at a clk edge) forces: col_out=4'b1110, key_code=0, key_valid=0, key_held=0, state IDLE. Also clears all counters and the snapshot, and sets both synchronizer stages to 4'b1111. Reset takes priority over every other event, including mid-scan and mid-debounce; no key_valid pulse may follow reset.
- row_in passes through a 2-flop synchronizer before any use.
- Column timer counts 0..SCAN_DIV-1. At terminal count it does two things:
  - captures the synchronized rows (inverted, so 1 = pressed) into snapshot bits [col*4+3:col*4];
  - advances col_out to the next column. Sequence is 0,1,2,3,0; wrap is 4'b0111 -> 4'b1110.
- A full scan takes 4*SCAN_DIV cycles. End-of-scan is the terminal count of column 3.
- At end-of-scan the candidate is formed from the 16-bit snapshot:
  - exactly one bit set -> candidate = that key's code;
  - zero bits set -> candidate = NONE;
  - two or more bits set -> candidate = NONE (ghosting/multi-press is rejected).
- Stability counter (saturates at DEBOUNCE_SCANS):
  - resets to 1 if the candidate differs from the previous scan's candidate;
  - otherwise increments.
- FSM, evaluated only at end-of-scan:
  - IDLE: if candidate != NONE -> PRESS_DB.
  - PRESS_DB: if candidate returns to NONE -> IDLE. If stable count reaches DEBOUNCE_SCANS with a non-NONE candidate -> HELD; key_code <= candidate, key_valid pulses, key_held <= 1.
  - HELD: if candidate != latched key_code (NONE or another key) -> REL_DB.
  - REL_DB: if candidate == key_code again -> HELD, with no new pulse. If candidate NONE stable for DEBOUNCE_SCANS -> IDLE, key_held <= 0. If a different key is stable for DEBOUNCE_SCANS -> HELD with the new code and a new pulse; key_held stays 1.
- key_valid rises exactly one clk after the end-of-scan edge that accepts the key. It is high for exactly one cycle. key_valid is never asserted while reset=0.
- Worst-case press latency = 2 sync + up to DEBOUNCE_SCANS+1 full scans + 1 cycles.

Optional Feature:
KEYPAD_REPEAT_EN:
- Defined: while in HELD, a repeat counter counts end-of-scans. Every REPEAT_SCANS scans it re-pulses key_valid with the same key_code. The counter clears on entry to HELD and on leaving HELD.
- Undefined: no repeat logic is synthesised; exactly one key_valid per accepted press. REPEAT_SCANS is ignored.

Test Plan:
- Reset with rows idle (4'b1111) -> col_out=1110, all outputs 0. Over 64 cycles col_out steps 1110,1101,1011,0111 every 4 clks and wraps; key_valid never pulses.
- Defaults; hold row 2 low only while col 1 is driven (key 9) -> one key_valid pulse with key_code=9 within 2+4*16+1 cycles of press start; key_held=1; no second pulse while held; with KEYPAD_REPEAT_EN, a pulse every 128 cycles.
- Release key 9 -> key_held falls 3 full scans after the first all-idle scan; key_code stays 9.
- Key 5 bouncing (pressed alternate scans for 6 scans, then stable) -> no pulse during bounce; exactly one pulse (code 5) after 3 stable scans.
- Keys 0 and 15 pressed together -> no key_valid, key_held stays 0. Release 15 -> key 0 accepted after 3 scans.
- Deassert-then-assert reset (reset=0) while in PRESS_DB with key 3 pending -> outputs return to reset values the next edge. No pulse for key 3 until 3 fresh stable scans after reset release.
